serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder/subtractor that consumes a 1-bit sum/carry cell per cycle and accumulates a WIDTH-bit result.
- Sits directly downstream of the half/full adder cells in the ALU datapath; area-reduced alternative to the parallel ripple adder.
- Internal bit-slice is built from two half-adder stages plus an OR: sum = a^b^c, carry = ab | c(a^b).
- Carry is held in a flip-flop between cycles. Start/done handshake with the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits (legal values: 2 to 64).

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request a new operation; sampled only when not busy
- i_sub  input  1  0 = A+B, 1 = A-B (two's complement: B inverted, carry-in = 1)
- i_data_a  input  WIDTH  operand A
- i_data_b  input  WIDTH  operand B
- o_busy  output  1  high while the serial computation is running
- o_done  output  1  one-cycle pulse when the result becomes valid
- o_data  output  WIDTH  result; held stable between done pulses
- o_carry  output  1  carry out of the MSB (for subtract: 1 = no borrow)
- o_overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; the shift registers, carry flip-flop and bit counter clear.
  - o_busy=0, o_done=0, o_data=0, o_carry=0, o_overflow=0.
  - A reset during RUN aborts the operation and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On i_start=1, latch A into shift reg SA and B^{WIDTH{i_sub}} into SB.
  - Set carry_ff = i_sub and counter = 0, then go to RUN.
- RUN (o_busy=1), each cycle:
  - s = SA[0]^SB[0]^carry_ff.
  - Shift s into the MSB of the partial-result register while SA and SB shift right by 1.
  - Update carry_ff; counter += 1.
  - On the cycle the counter reaches WIDTH-1:
    - Capture the carry into the MSB slice (the pre-update carry_ff) for overflow.
    - Go to DONE.
- DONE (one cycle):
  - o_done=1. o_data, o_carry and o_overflow update at entry to DONE.
  - Next state is IDLE, or RUN if i_start=1 in this cycle (back-to-back, same latching rules as IDLE).
- Latency: start sampled at edge 0; RUN occupies WIDTH cycles; o_done is high for the cycle after edge WIDTH. For WIDTH=32, o_done is high in cycle 33 relative to the start cycle.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- i_start while o_busy=1 is ignored. It is not queued and has no effect on the operation in flight.
- Operand ports are sampled only on the accepting edge. Later changes do not affect the result.
- o_data, o_carry and o_overflow are unchanged during RUN; they keep the previous result until the next DONE.
- Counter width is $clog2(WIDTH). The counter is not allowed to wrap during RUN.
- Arithmetic is modulo 2^WIDTH. o_carry and o_overflow are computed for every operation regardless of i_sub.

Test Plan:
- Addition latency: reset, then A=5, B=3, sub=0, start 1 cycle.
  - Required: o_busy high for 32 cycles, then o_done for exactly 1 cycle.
  - Required values: o_data=0x00000008, o_carry=0, o_overflow=0.
- Unsigned carry: A=0xFFFFFFFF, B=0x00000001, add.
  - Required: o_data=0x00000000, o_carry=1, o_overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add.
  - Required: o_data=0x80000000, o_carry=0, o_overflow=1.
- Subtraction: A=5, B=3, sub=1 gives o_data=0x00000002, o_carry=1. Then A=3, B=5, sub=1 gives o_data=0xFFFFFFFE, o_carry=0, o_overflow=0.
- Busy handling: pulse i_start at RUN cycle 10 with different operands.
  - Required: ignored; the first result is produced unchanged.
  - Then assert i_start in the DONE cycle. Required: a new RUN starts immediately and o_done pulses again 33 cycles later.
- Mid-operation reset: assert i_rst_n=0 asynchronously at RUN cycle 15.
  - Required: all outputs are 0 immediately and no o_done follows.
  - After release, a fresh 1+1 operation gives o_data=2.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one sum/carry slice per cycle, WIDTH-bit result
// with start/busy/done handshake, carry-out and signed-overflow flags.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry_ff;
  logic [CNT_W-1:0] cnt;

  logic half_sum;
  logic half_gen;
  logic slice_sum;
  logic slice_carry;

  // Full-adder slice from two half-adder stages plus an OR
  always_comb begin
    half_sum    = sa[0] ^ sb[0];
    half_gen    = sa[0] & sb[0];
    slice_sum   = half_sum ^ carry_ff;
    slice_carry = half_gen | (half_sum & carry_ff);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      carry_ff   <= 1'b0;
      cnt        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_data     <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE (back-to-back operation)
        IDLE, DONE: begin
          if (i_start) begin
            sa       <= i_data_a;
            sb       <= i_data_b ^ {WIDTH{i_sub}};
            carry_ff <= i_sub;
            cnt      <= '0;
            o_busy   <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          res      <= {slice_sum, res[WIDTH-1:1]};
          carry_ff <= slice_carry;
          if (cnt == LAST) begin
            // carry_ff here is the carry into the MSB slice
            cnt        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_data     <= {slice_sum, res[WIDTH-1:1]};
            o_carry    <= slice_carry;
            o_overflow <= carry_ff ^ slice_carry;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
